// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;
    localparam int REG_X0 = 0;
endpackage

// File: rtl/dmem_wait_fsm.sv
// dmem_wait_fsm: data-memory handshake FSM; freezes the pipe while M waits, aborts on timeout.
module dmem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic mem_access_m,
    input  logic mem_ack,
    output logic mem_req,
    output logic freeze,
    output logic mem_err
);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    mem_state_t state;
    logic [TW-1:0] tout;
    logic tmo;
    assign tmo = state == MEM_WAIT && !mem_ack && tout == TW'(MEM_TIMEOUT);
    assign mem_req = !reset && (state == MEM_WAIT || mem_access_m);
    // The final timed-out WAIT cycle releases the freeze so the abandoned access drains.
    assign freeze = !reset && (state == MEM_IDLE ? mem_access_m && !mem_ack : !mem_ack && !tmo);
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= MEM_IDLE;
            tout <= '0;
            mem_err <= 1'b0;
        end else if (state == MEM_IDLE) begin
            if (mem_access_m && !mem_ack) begin
                state <= MEM_WAIT;
                tout <= TW'(1);
            end
        end else begin
            tout <= tout + TW'(1);
            if (mem_ack || tmo) state <= MEM_IDLE;
            if (tmo) mem_err <= 1'b1;
        end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the F,D,E,B,M,W pipeline.
// Perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_b,
    input  logic              load_e,
    input  logic              load_b,
    input  logic              mispredict_b,
    input  logic              mem_access_m,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_b,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_b,
    output logic              flush_w,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam logic [REG_AW-1:0] X0 = REG_AW'(REG_X0);
    logic freeze, hit_e, hit_b, mp, lu;
    dmem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
        .clk(clk), .reset(reset), .mem_access_m(mem_access_m), .mem_ack(mem_ack),
        .mem_req(mem_req), .freeze(freeze), .mem_err(mem_err)
    );
    assign hit_e = load_e && rd_e != X0 && (rd_e == rs1_d || rd_e == rs2_d);
    assign hit_b = load_b && rd_b != X0 && (rd_b == rs1_d || rd_b == rs2_d);
    // Priority: memory freeze, then mispredict flush, then load-use bubble.
    assign mp = !reset && !freeze && mispredict_b;
    assign lu = !reset && !freeze && !mispredict_b && (hit_e || hit_b);
    assign stall_f = freeze || lu;
    assign stall_d = freeze || lu;
    assign stall_e = freeze;
    assign stall_b = freeze;
    assign stall_m = freeze;
    assign flush_d = mp;
    assign flush_e = mp || lu;
    assign flush_b = mp;
    assign flush_w = freeze;
`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f || stall_d || stall_e || stall_b || stall_m) stall_cnt <= stall_cnt + CNT_W'(1);
            if (mp) flush_cnt <= flush_cnt + CNT_W'(1);
        end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, hand sequences and randomized model check for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
    localparam int TMO = 15;
    logic clk = 1'b0, reset = 1'b1;
    logic [4:0] rs1_d = '0, rs2_d = '0, rd_e = '0, rd_b = '0;
    logic load_e = 0, load_b = 0, mispredict_b = 0, mem_access_m = 0, mem_ack = 0;
    logic mem_req, stall_f, stall_d, stall_e, stall_b, stall_m;
    logic flush_d, flush_e, flush_b, flush_w, mem_err;
    logic [31:0] stall_cnt, flush_cnt;
    logic [10:0] outs;
    int tests = 0, fails = 0;
    int pend = 0;
    bit err = 0;
    logic [31:0] scnt = '0, fcnt = '0;
    logic s_sm, s_req, s_err;

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e), .rd_b(rd_b),
        .load_e(load_e), .load_b(load_b), .mispredict_b(mispredict_b),
        .mem_access_m(mem_access_m), .mem_ack(mem_ack), .mem_req(mem_req),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_b(stall_b),
        .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e), .flush_b(flush_b),
        .flush_w(flush_w), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;
    assign outs = {mem_req, stall_f, stall_d, stall_e, stall_b, stall_m,
                   flush_d, flush_e, flush_b, flush_w, mem_err};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; drives a cycle, checks at negedge, advances the model, returns at next posedge+1.
    task automatic step(input logic [4:0] r1, r2, re, rb, input logic le, lb, mp, ma, ak);
        bit busy, fz, tmo, hit, emp, elu;
        int age;
        rs1_d = r1; rs2_d = r2; rd_e = re; rd_b = rb;
        load_e = le; load_b = lb; mispredict_b = mp; mem_access_m = ma; mem_ack = ak;
        #4;
        busy = pend > 0 || ma;
        age = pend + 1;
        fz = busy && !ak && age <= TMO;
        tmo = busy && !ak && age > TMO;
        hit = (le && re != 0 && (re == r1 || re == r2)) || (lb && rb != 0 && (rb == r1 || rb == r2));
        emp = !fz && mp;
        elu = !fz && !mp && hit;
        chk("outs", 64'(outs), 64'({busy, fz | elu, fz | elu, fz, fz, fz, emp, emp | elu, emp, fz, err}));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(scnt));
        chk("flush_cnt", 64'(flush_cnt), 64'(fcnt));
`else
        chk("cnt_tied", 64'({stall_cnt, flush_cnt}), 64'd0);
`endif
        s_sm = stall_m; s_req = mem_req; s_err = mem_err;
        if (tmo) err = 1;
        pend = (busy && !ak && !tmo) ? age : 0;
        if (fz || elu) scnt = scnt + 1;
        if (emp) fcnt = fcnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ma, input logic ak);
        step(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, ma, ak);
    endtask

    task automatic finish_reset();
        @(posedge clk);
        #1;
        reset = 0;
        pend = 0; err = 0; scnt = '0; fcnt = '0;
    endtask

    typedef struct {
        logic [4:0] r1, r2, re, rb;
        logic le, lb, mp;
        logic sfd, fe, fdb;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int frz;
        tbl[0] = '{5'd5, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{5'd5, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{5'd3, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{5'd6, 5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{5'd1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{5'd2, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{5'd9, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        #1;
        chk("reset_outs", 64'(outs), 64'd0);
        finish_reset();
        foreach (tbl[i]) begin
            step(tbl[i].r1, tbl[i].r2, tbl[i].re, tbl[i].rb, tbl[i].le, tbl[i].lb, tbl[i].mp, 0, 0);
            chk($sformatf("tbl%0d_stall_f", i), 64'(dut.stall_f === 1'bx), 64'd0);
        end
        // Re-check the table expectations directly, sampled mid-cycle.
        foreach (tbl[i]) begin
            rs1_d = tbl[i].r1; rs2_d = tbl[i].r2; rd_e = tbl[i].re; rd_b = tbl[i].rb;
            load_e = tbl[i].le; load_b = tbl[i].lb; mispredict_b = tbl[i].mp;
            mem_access_m = 0; mem_ack = 0;
            #4;
            chk($sformatf("tbl%0d_stall_fd", i), 64'({stall_f, stall_d}), 64'({tbl[i].sfd, tbl[i].sfd}));
            chk($sformatf("tbl%0d_flush_e", i), 64'(flush_e), 64'(tbl[i].fe));
            chk($sformatf("tbl%0d_flush_db", i), 64'({flush_d, flush_b}), 64'({tbl[i].fdb, tbl[i].fdb}));
            if (tbl[i].mp) fcnt = fcnt + 1;
            else if (tbl[i].sfd) scnt = scnt + 1;
            @(posedge clk);
            #1;
        end
        idle(0, 0);
        frz = 0;
        step(5'd5, 5'd0, 5'd5, 5'd0, 1, 0, 1, 1, 0); frz += s_sm;
        idle(1, 0); frz += s_sm;
        idle(1, 1); frz += s_sm;
        chk("ack3_freeze_cycles", 64'(frz), 64'd2);
        idle(0, 0);
        chk("after_ack_req", 64'(s_req), 64'd0);
        frz = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1, 0);
            if (!s_sm) break;
            frz++;
        end
        chk("timeout_freeze_cycles", 64'(frz), 64'(TMO));
        idle(0, 0);
        chk("timeout_err", 64'({s_err, s_req}), 64'b10);
        idle(0, 1);
        chk("err_sticky", 64'(s_err), 64'd1);
        idle(1, 0);
        reset = 1;
        mem_access_m = 1; load_e = 1; rd_e = 5'd5; rs1_d = 5'd5; mispredict_b = 1;
        #2;
        chk("reset_in_wait_outs", 64'(outs), 64'd0);
        chk("reset_in_wait_cnt", 64'({stall_cnt, flush_cnt}), 64'd0);
        finish_reset();
        idle(0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic ak;
            ak = (i < 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, ak);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
